gonso_sequencer: RTL and testbench

Wishbone-controlled job sequencer for the Honzales datapath. Firmware pushes operand/color jobs into an input FIFO; the sequencer issues one job at a time to the datapath, waits the configured pipeline latency, and captures the result and color into a result FIFO. Firmware pops results from the result FIFO. It sits beside the existing gonso register block on the same Wishbone slave window and takes over the datapath's `io_input`/`io_color_in` drive.

---
 rtl/gonso_seq_pkg.sv | 45 ++++
 rtl/gonso_sequencer_if.sv | 21 ++
 rtl/gonso_fifo.sv | 52 +++++
 rtl/gonso_sequencer.sv | 171 +++++++++++++++++
 tb/tb_gonso_sequencer.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gonso_seq_pkg.sv
// Shared constants, register map and state encoding for the gonso job sequencer.
package gonso_seq_pkg;

  localparam int OP_W  = 20;
  localparam int COL_W = 8;
  localparam int JOB_W = OP_W + COL_W;

  localparam logic [3:0] CMD_OFS    = 4'h0;
  localparam logic [3:0] RESULT_OFS = 4'h4;
  localparam logic [3:0] STATUS_OFS = 4'h8;
  localparam logic [3:0] CTRL_OFS   = 4'hC;

  localparam int ST_IN_LSB  = 0;
  localparam int ST_RES_LSB = 5;
  localparam int ST_BUSY    = 10;
  localparam int ST_OVF     = 11;
  localparam int ST_UNF     = 12;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_FLUSH  = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE
  } seq_state_e;

  function automatic logic [31:0] status_word(input logic [4:0] in_cnt,
                                              input logic [4:0] res_cnt,
                                              input logic       busy,
                                              input logic       ovf,
                                              input logic       unf);
    logic [31:0] w;
    w = '0;
    w[ST_IN_LSB +: 5]  = in_cnt;
    w[ST_RES_LSB +: 5] = res_cnt;
    w[ST_BUSY]         = busy;
    w[ST_OVF]          = ovf;
    w[ST_UNF]          = unf;
    return w;
  endfunction

endpackage

// File: rtl/gonso_sequencer_if.sv
// Wishbone slave window signals shared between firmware bus and the sequencer.
interface gonso_sequencer_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic [31:0] wishbone_address;
  logic        wbs_we_i;
  logic [31:0] wbs_dat_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wishbone_address, wbs_we_i, wbs_dat_i, wbs_sel_i,
    output wbs_dat_o, wbs_ack_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wishbone_address, wbs_we_i, wbs_dat_i, wbs_sel_i,
    input  wbs_dat_o, wbs_ack_o
  );
endinterface

// File: rtl/gonso_fifo.sv
// Power-of-two synchronous FIFO with a clear input; a push to a full FIFO
// is accepted only when a pop happens on the same edge.
module gonso_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wptr_q] <= wdata;
  end
endmodule

// File: rtl/gonso_sequencer.sv
// Wishbone-controlled job sequencer: input/result FIFOs, CTRL/STATUS registers
// and the issue/wait/capture FSM driving the Honzales datapath.
module gonso_sequencer
  import gonso_seq_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter int          LATENCY   = 1,
  parameter logic [31:0] BASE_ADDR = 32'h30030010
) (
  input  logic             clk,
  input  logic             rst,
  gonso_sequencer_if.slave wb,
  output logic [OP_W-1:0]  dp_input,
  output logic [COL_W-1:0] dp_color_in,
  input  logic [OP_W-1:0]  dp_output,
  input  logic [COL_W-1:0] dp_color_out,
  output logic             irq
);
  // state   | meaning
  // IDLE    | waiting for enable, a queued job and result space
  // ISSUE   | pop input FIFO, drive datapath, load wait timer
  // WAIT    | timer counts down the datapath latency
  // CAPTURE | push datapath result into the result FIFO
  localparam int         CW        = $clog2(DEPTH) + 1;
  localparam logic [3:0] WAIT_INIT = 4'(LATENCY - 1);

  seq_state_e       state_q, state_d;
  logic [3:0]       wcnt_q, wcnt_d;
  logic             ack_q;
  logic [31:0]      dat_o_q, rdata_d;
  logic             enable_q, irq_en_q, ovf_q, unf_q;
  logic [OP_W-1:0]  dp_input_q;
  logic [COL_W-1:0] dp_color_q;

  logic             req, wr, rd, wr_cmd, rd_res, wr_status, wr_ctrl, flush;
  logic             in_pop, res_push, dp_load;
  logic             in_full, in_empty, res_full, res_empty;
  logic [CW-1:0]    in_count, res_count;
  logic [JOB_W-1:0] in_rdata, res_rdata;
  logic [3:0]       ofs;
  logic             unused_bits;

  assign ofs = wb.wishbone_address[3:0];
  assign req = wb.wbs_cyc_i & wb.wbs_stb_i & ~ack_q &
               (wb.wishbone_address[31:4] == BASE_ADDR[31:4]);
  assign wr  = req & wb.wbs_we_i & wb.wbs_sel_i[0];
  assign rd  = req & ~wb.wbs_we_i;

  assign wr_cmd    = wr & (ofs == CMD_OFS);
  assign wr_status = wr & (ofs == STATUS_OFS);
  assign wr_ctrl   = wr & (ofs == CTRL_OFS);
  assign rd_res    = rd & (ofs == RESULT_OFS);
  assign flush     = wr_ctrl & wb.wbs_dat_i[CTRL_FLUSH];

  assign unused_bits = ^{wb.wbs_dat_i[31:JOB_W], wb.wbs_sel_i[3:1]};

  gonso_fifo #(.WIDTH(JOB_W), .DEPTH(DEPTH)) u_in_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (wr_cmd),
    .pop   (in_pop),
    .wdata (wb.wbs_dat_i[JOB_W-1:0]),
    .rdata (in_rdata),
    .full  (in_full),
    .empty (in_empty),
    .count (in_count)
  );

  gonso_fifo #(.WIDTH(JOB_W), .DEPTH(DEPTH)) u_res_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (res_push),
    .pop   (rd_res),
    .wdata ({dp_color_out, dp_output}),
    .rdata (res_rdata),
    .full  (res_full),
    .empty (res_empty),
    .count (res_count)
  );

  always_comb begin
    rdata_d = '0;
    if (rd) begin
      case (ofs)
        RESULT_OFS: rdata_d = res_empty ? 32'h0 : {4'b0, res_rdata};
        STATUS_OFS: rdata_d = status_word(5'(in_count), 5'(res_count),
                                          state_q != S_IDLE, ovf_q, unf_q);
        CTRL_OFS:   rdata_d = {30'b0, irq_en_q, enable_q};
        default:    rdata_d = '0;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    in_pop   = 1'b0;
    res_push = 1'b0;
    dp_load  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable_q && !in_empty && !res_full) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        in_pop  = 1'b1;
        dp_load = 1'b1;
        wcnt_d  = WAIT_INIT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wcnt_q == '0) state_d = S_CAPTURE;
        else              wcnt_d  = wcnt_q - 1'b1;
      end
      S_CAPTURE: begin
        res_push = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // flush aborts whatever the job was doing, including a pending capture
    if (flush) begin
      state_d  = S_IDLE;
      in_pop   = 1'b0;
      res_push = 1'b0;
      dp_load  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wcnt_q     <= '0;
      ack_q      <= 1'b0;
      dat_o_q    <= '0;
      enable_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      dp_input_q <= '0;
      dp_color_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      ack_q   <= req;
      if (req) dat_o_q <= rdata_d;
      if (wr_ctrl) begin
        enable_q <= wb.wbs_dat_i[CTRL_EN];
        irq_en_q <= wb.wbs_dat_i[CTRL_IRQ_EN];
      end
      if (wr_status) begin
        ovf_q <= 1'b0;
        unf_q <= 1'b0;
      end else begin
        if (wr_cmd && in_full && !in_pop) ovf_q <= 1'b1;
        if (rd_res && res_empty)          unf_q <= 1'b1;
      end
      if (dp_load) begin
        dp_input_q <= in_rdata[OP_W-1:0];
        dp_color_q <= in_rdata[JOB_W-1:OP_W];
      end
    end
  end

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = dat_o_q;
  assign dp_input     = dp_input_q;
  assign dp_color_in  = dp_color_q;
  assign irq          = irq_en_q & ~res_empty;
endmodule

// File: tb/tb_gonso_sequencer.sv
// Self-checking bench for gonso_sequencer: queue-based job model, directed
// scenarios with literal expectations, then randomized register traffic.
`timescale 1ns/1ps
module tb_gonso_sequencer;
  localparam int          DEPTH   = 4;
  localparam int          LATENCY = 1;
  localparam logic [31:0] BASE    = 32'h30030010;
  localparam int          SETTLE  = (LATENCY + 3) * (DEPTH + 1) + 4;

  localparam logic [3:0] O_CMD = 4'h0, O_RES = 4'h4, O_STAT = 4'h8, O_CTRL = 4'hC;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] dp_input, dp_output;
  logic [7:0]  dp_color_in, dp_color_out;
  logic        irq;

  always #5 clk = ~clk;

  gonso_sequencer_if wb();

  gonso_sequencer #(.DEPTH(DEPTH), .LATENCY(LATENCY), .BASE_ADDR(BASE)) dut (
    .clk          (clk),
    .rst          (rst),
    .wb           (wb),
    .dp_input     (dp_input),
    .dp_color_in  (dp_color_in),
    .dp_output    (dp_output),
    .dp_color_out (dp_color_out),
    .irq          (irq)
  );

  // datapath stub: result = operand+1, color inverted, LATENCY register stages
  logic [27:0] pipe [LATENCY];
  always @(posedge clk) begin
    pipe[0] <= {~dp_color_in, dp_input + 20'd1};
    for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
  end
  assign {dp_color_out, dp_output} = pipe[LATENCY-1];

  // behavioural model: jobs move from input queue to result queue as soon as allowed
  logic [27:0] m_in[$];
  logic [27:0] m_res[$];
  bit          m_en, m_irq_en, m_ovf, m_unf;
  logic [27:0] m_last;
  bit          settled;
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [27:0] dp_fn(input logic [27:0] job);
    return {~job[27:20], job[19:0] + 20'd1};
  endfunction

  function automatic void m_settle();
    while (m_en && m_in.size() > 0 && m_res.size() < DEPTH) begin
      m_last = m_in.pop_front();
      m_res.push_back(dp_fn(m_last));
    end
  endfunction

  function automatic void m_reset();
    m_in.delete();
    m_res.delete();
    m_en = 0; m_irq_en = 0; m_ovf = 0; m_unf = 0;
    m_last = '0;
  endfunction

  function automatic logic [31:0] m_status();
    return {19'b0, m_unf, m_ovf, 1'b0, 5'(m_res.size()), 5'(m_in.size())};
  endfunction

  always @(negedge clk) begin
    if (settled && !rst) begin
      check("irq", 32'(irq), 32'(m_irq_en && (m_res.size() != 0)));
      check("dp_input", 32'(dp_input), 32'(m_last[19:0]));
      check("dp_color_in", 32'(dp_color_in), 32'(m_last[27:20]));
    end
  end

  task automatic xfer(input bit we, input logic [3:0] ofs, input logic [31:0] data,
                      input logic [3:0] sel, output logic [31:0] rdata);
    int n;
    settled = 0;
    wb.wbs_cyc_i        = 1'b1;
    wb.wbs_stb_i        = 1'b1;
    wb.wishbone_address = BASE + 32'(ofs);
    wb.wbs_we_i         = we;
    wb.wbs_dat_i        = data;
    wb.wbs_sel_i        = sel;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!wb.wbs_ack_o && n < 20);
    check("wb_ack_seen", 32'(wb.wbs_ack_o), 32'd1);
    rdata = wb.wbs_dat_o;
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    @(posedge clk); #1;
    check("wb_ack_pulse", 32'(wb.wbs_ack_o), 32'd0);
  endtask

  task automatic op_write(input logic [3:0] ofs, input logic [31:0] data, input logic [3:0] sel);
    logic [31:0] r;
    xfer(1'b1, ofs, data, sel, r);
    if (sel[0]) begin
      case (ofs)
        O_CMD:  if (m_in.size() >= DEPTH) m_ovf = 1; else m_in.push_back(data[27:0]);
        O_STAT: begin m_ovf = 0; m_unf = 0; end
        O_CTRL: begin
          m_en = data[0];
          m_irq_en = data[1];
          if (data[2]) begin m_in.delete(); m_res.delete(); end
        end
        default: ;
      endcase
    end
    m_settle();
  endtask

  task automatic op_read(input logic [3:0] ofs, input string name, output logic [31:0] r);
    logic [31:0] exp;
    exp = '0;
    case (ofs)
      O_RES:   if (m_res.size() != 0) exp = {4'b0, m_res.pop_front()}; else m_unf = 1;
      O_STAT:  exp = m_status();
      O_CTRL:  exp = {30'b0, m_irq_en, m_en};
      default: exp = '0;
    endcase
    xfer(1'b0, ofs, 32'h0, 4'hF, r);
    check(name, r, exp);
    m_settle();
  endtask

  task automatic settle();
    repeat (SETTLE) @(posedge clk);
    #1;
    settled = 1;
  endtask

  task automatic do_reset();
    settled = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", 32'(wb.wbs_ack_o), 32'd0);
    check("rst_dat_o", wb.wbs_dat_o, 32'd0);
    check("rst_dp_input", 32'(dp_input), 32'd0);
    check("rst_dp_color", 32'(dp_color_in), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    rst = 1'b0;
    m_reset();
  endtask

  initial begin
    logic [31:0] r, d;
    logic [3:0]  ofs, sel;
    int          kind;
    bit          seen;

    wb.wbs_cyc_i = 0; wb.wbs_stb_i = 0; wb.wbs_we_i = 0;
    wb.wishbone_address = BASE; wb.wbs_dat_i = 0; wb.wbs_sel_i = 0;
    settled = 0;
    m_reset();

    // reset state
    do_reset();
    settle();
    op_read(O_STAT, "t1_status", r);
    check("t1_status_lit", r, 32'h0);

    // single job
    op_write(O_CTRL, 32'h3, 4'hF);
    op_write(O_CMD, 32'h00A00005, 4'hF);
    seen = 0;
    for (int c = 0; c < 3 && !seen; c++) begin
      @(posedge clk); #1;
      if (irq) seen = 1;
    end
    check("t2_irq_rise", 32'(seen), 32'd1);
    settle();
    op_read(O_RES, "t2_result", r);
    check("t2_result_lit", r, 32'h0F500006);
    check("t2_irq_fall", 32'(irq), 32'd0);
    op_read(O_STAT, "t2_status", r);
    check("t2_res_count", 32'(r[9:5]), 32'd0);

    // overflow
    op_write(O_CTRL, 32'h0, 4'hF);
    for (int i = 0; i < 5; i++) op_write(O_CMD, 32'h00100000 + 32'(i), 4'hF);
    settle();
    op_read(O_STAT, "t3_status", r);
    check("t3_status_lit", r, 32'h00000804);
    op_write(O_STAT, 32'h0, 4'hF);
    op_read(O_STAT, "t3_cleared", r);
    check("t3_cleared_lit", r, 32'h00000004);

    // underflow
    op_read(O_RES, "t4_result", r);
    check("t4_result_lit", r, 32'h0);
    op_read(O_STAT, "t4_status", r);
    check("t4_status_lit", r, 32'h00001004);
    op_write(O_CTRL, 32'h4, 4'hF);
    op_write(O_STAT, 32'h0, 4'hF);
    settle();
    op_read(O_STAT, "t4_flushed", r);
    check("t4_flushed_lit", r, 32'h0);

    // backpressure and ordering
    op_write(O_CTRL, 32'h1, 4'hF);
    for (int i = 0; i < 6; i++) op_write(O_CMD, {4'b0, 8'($urandom), 20'(i)}, 4'hF);
    settle();
    op_read(O_STAT, "t5_status", r);
    check("t5_status_lit", r, 32'h00000082);
    for (int i = 0; i < 4; i++) begin
      op_read(O_RES, "t5_result", r);
      check("t5_order", 32'(r[19:0]), 32'(i + 1));
    end
    settle();
    for (int i = 4; i < 6; i++) begin
      op_read(O_RES, "t5_result", r);
      check("t5_order", 32'(r[19:0]), 32'(i + 1));
    end
    settle();

    // flush while the job is in WAIT
    op_write(O_CTRL, 32'h3, 4'hF);
    op_write(O_CMD, 32'h03300123, 4'hF);
    @(posedge clk); #1;
    op_write(O_CTRL, 32'h7, 4'hF);
    settle();
    op_read(O_STAT, "t6_flush_status", r);
    check("t6_flush_lit", r, 32'h0);
    check("t6_flush_irq", 32'(irq), 32'd0);

    // reset while the job is in WAIT
    op_write(O_CMD, 32'h04400321, 4'hF);
    @(posedge clk); #1;
    do_reset();
    settle();
    op_read(O_STAT, "t6_rst_status", r);
    check("t6_rst_status_lit", r, 32'h0);
    op_read(O_CTRL, "t6_rst_ctrl", r);
    check("t6_rst_ctrl_lit", r, 32'h0);

    // randomized traffic
    for (int k = 0; k < 250; k++) begin
      kind = $urandom_range(0, 99);
      sel  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
      d    = $urandom;
      if (kind < 35) begin
        op_write(O_CMD, d, sel);
      end else if (kind < 60) begin
        op_read(O_RES, "rnd_result", r);
      end else if (kind < 72) begin
        op_read(O_STAT, "rnd_status", r);
      end else if (kind < 77) begin
        op_write(O_STAT, d, sel);
      end else if (kind < 90) begin
        d[0] = ($urandom_range(0, 3) != 0);
        d[2] = ($urandom_range(0, 9) == 0);
        op_write(O_CTRL, d, sel);
      end else if (kind < 94) begin
        op_read(O_CTRL, "rnd_ctrl", r);
      end else begin
        ofs = 4'($urandom_range(0, 15));
        if (ofs[1:0] == 2'b00) ofs[0] = 1'b1;
        if (kind < 97) op_write(ofs, d, 4'hF);
        else           op_read(ofs, "rnd_unmapped", r);
      end
      settle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
